rgbw_pwm_fader: RTL



---
 rtl/rgbw_pwm_fader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rgbw_pwm_fader.sv
// rtl/rgbw_pwm_fader.sv - RGBW PWM output stage with period-synchronous target update; optional fade under RGBW_PWM_FADE_EN
module rgbw_pwm_fader #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] in_duty,
  input  logic [WIDTH-1:0]   fade_step,
  output logic [3:0]         pwm_out,
  output logic               period_start,
  output logic               busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]             pre_q, pre_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      tick, bnd;
  logic                      pending_q, pending_d;
  logic [3:0][WIDTH-1:0]     shadow_q, shadow_d;
  logic [3:0][WIDTH-1:0]     cur_q, cur_d;
  logic [3:0][WIDTH-1:0]     tgt_q, tgt_d;
  logic [3:0][WIDTH-1:0]     teff;
  logic [3:0]                pwm_q, pwm_d;
  logic                      ps_q;
  logic                      accept;

`ifdef RGBW_PWM_FADE_EN
  // One fade step toward tgt, landing exactly on tgt once within reach
  function automatic logic [WIDTH-1:0] fade_next(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt,
                                                 input logic [WIDTH-1:0] step);
    logic [WIDTH:0] diff;
    logic [WIDTH:0] mag;
    diff = {1'b0, tgt} - {1'b0, cur};
    mag  = diff[WIDTH] ? ((~diff) + 1'b1) : diff;
    if (mag <= {1'b0, step}) return tgt;
    else if (diff[WIDTH])    return cur - step;
    else                     return cur + step;
  endfunction
`else
  logic unused_fade_step;
  assign unused_fade_step = ^fade_step;
`endif

  // Prescaler and PWM counter; both held at zero while disabled so a period restarts cleanly
  always_comb begin
    tick  = ena && (pre_q == PRE_LAST);
    bnd   = tick && (cnt_q == '1);
    pre_d = '0;
    cnt_d = '0;
    if (ena) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    end
  end

  // Handshake into the shadow register and boundary-synchronous target/duty update
  always_comb begin
    accept    = in_valid && !pending_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    teff      = pending_q ? shadow_q : tgt_q;
    if (accept) begin
      shadow_d  = in_duty;
      pending_d = 1'b1;
    end else if (bnd) begin
      pending_d = 1'b0;
    end
    if (bnd) begin
      tgt_d = teff;
      for (int i = 0; i < 4; i++) begin
`ifdef RGBW_PWM_FADE_EN
        cur_d[i] = fade_next(cur_q[i], teff[i], fade_step);
`else
        cur_d[i] = teff[i];
`endif
      end
    end
  end

  // PWM compare against the applied duty of each channel
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < 4; i++) begin
      pwm_d[i] = ena && (cnt_q < cur_q[i]);
    end
  end

  // State and registered outputs; everything returns to zero on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      cur_q     <= '0;
      tgt_q     <= '0;
      pwm_q     <= '0;
      ps_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      pwm_q     <= pwm_d;
      ps_q      <= bnd;
    end
  end

  assign in_ready     = !pending_q;
  assign busy         = pending_q || (cur_q != tgt_q);
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule
